// File: rtl/imem_prog.sv
// Field-programmable instruction memory: synchronous-read RAM that is cleared after reset
// and refilled at run time through a byte-serial little-endian load port.
module imem_prog #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          rd_en,
  output logic [N-1:0]  q,
  output logic          q_valid,
  output logic          busy,
  input  logic          prog_en,
  input  logic          prog_valid,
  input  logic [7:0]    prog_byte,
  output logic          prog_ready,
  output logic [AW:0]   prog_count,
  output logic          prog_ovf
);

  localparam int NB    = N / 8;
  localparam int IW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW:0]     wptr_q, wptr_d;
  logic [N-1:0]    asm_q, asm_d;
  logic            ovf_q, ovf_d;
  logic            qv_q, qv_d;
  logic [N-1:0]    q_q;
  logic            re;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [N-1:0]    wdata;

  logic [N-1:0]    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      idx_q     <= '0;
      wptr_q    <= '0;
      asm_q     <= '0;
      ovf_q     <= 1'b0;
      qv_q      <= 1'b0;
      q_q       <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      idx_q     <= idx_d;
      wptr_q    <= wptr_d;
      asm_q     <= asm_d;
      ovf_q     <= ovf_d;
      qv_q      <= qv_d;
      if (re) q_q <= mem[addr];
    end
  end

  // Single write port shared by the clear sweep and the loader; writes are suppressed during reset.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    idx_d     = idx_q;
    wptr_d    = wptr_q;
    asm_d     = asm_q;
    ovf_d     = ovf_q;
    qv_d      = qv_q;
    re        = 1'b0;
    we        = 1'b0;
    waddr     = clr_ptr_q;
    wdata     = '0;

    case (state_q)
      CLEAR: begin
        we        = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (rd_en) begin
          re   = 1'b1;
          qv_d = 1'b1;
        end
        if (prog_en) begin
          state_d = LOAD;
          wptr_d  = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        qv_d = 1'b0;
        if (prog_valid) begin
          if (prog_ready) begin
            asm_d[{idx_q, 3'b000} +: 8] = prog_byte;
            if (idx_q == IW'(NB - 1)) begin
              we     = 1'b1;
              waddr  = wptr_q[AW-1:0];
              wdata  = asm_d;
              wptr_d = wptr_q + 1'b1;
              idx_d  = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            ovf_d = 1'b1;
          end
        end
        // Leaving load mode abandons any partially assembled word.
        if (!prog_en) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign q          = q_q;
  assign q_valid    = qv_q && (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign prog_ready = (state_q == LOAD) && !wptr_q[AW];
  assign prog_count = wptr_q;
  assign prog_ovf   = ovf_q;

endmodule

// File: tb/tb_imem_prog.sv
// Self-checking bench for imem_prog: fetch scoreboard, table-driven readback, and load/reset sequences.
module tb_imem_prog;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  addr;
  logic        rd_en;
  logic [31:0] q;
  logic        q_valid;
  logic        busy;
  logic        prog_en;
  logic        prog_valid;
  logic [7:0]  prog_byte;
  logic        prog_ready;
  logic [6:0]  prog_count;
  logic        prog_ovf;

  int tests = 0;
  int fails = 0;

  logic [31:0] modelMem [64];
  logic [31:0] modelAsm;
  int          modelIdx;
  int          modelCount;
  logic        modelOvf;
  logic [31:0] sbQ [$];

  typedef struct {
    logic [5:0]  a;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [4];

  imem_prog #(.N(32), .AW(6)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .q(q), .q_valid(q_valid),
    .busy(busy), .prog_en(prog_en), .prog_valid(prog_valid), .prog_byte(prog_byte),
    .prog_ready(prog_ready), .prog_count(prog_count), .prog_ovf(prog_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    int cnt;
    @(negedge clk);
    reset = 1'b1; prog_en = 1'b0; prog_valid = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    checkOutput("rst q", 64'(q), 64'h0);
    checkOutput("rst q_valid", 64'(q_valid), 64'h0);
    checkOutput("rst busy", 64'(busy), 64'h1);
    checkOutput("rst prog_ready", 64'(prog_ready), 64'h0);
    checkOutput("rst prog_count", 64'(prog_count), 64'h0);
    checkOutput("rst prog_ovf", 64'(prog_ovf), 64'h0);
    reset = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("busy cycles after reset", 64'(cnt), 64'd64);
    for (int i = 0; i < 64; i++) modelMem[i] = 32'h0;
  endtask

  task automatic fetch(input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] want;
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    sbQ.push_back(exp);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    want = sbQ.pop_front();
    checkOutput($sformatf("fetch q addr %0d", a), 64'(q), 64'(want));
    checkOutput($sformatf("fetch q_valid addr %0d", a), 64'(q_valid), 64'h1);
  endtask

  task automatic startLoad();
    @(negedge clk);
    prog_en = 1'b1;
    @(negedge clk);
    checkOutput("load busy", 64'(busy), 64'h1);
    checkOutput("load q_valid", 64'(q_valid), 64'h0);
    modelIdx = 0; modelCount = 0; modelOvf = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    checkOutput($sformatf("prog_ready at word %0d", modelCount), 64'(prog_ready),
                64'(modelCount < 64));
    prog_valid = 1'b1; prog_byte = b;
    @(negedge clk);
    prog_valid = 1'b0;
    if (modelCount < 64) begin
      modelAsm[modelIdx*8 +: 8] = b;
      modelIdx++;
      if (modelIdx == 4) begin
        modelMem[modelCount] = modelAsm;
        modelCount++;
        modelIdx = 0;
      end
    end else begin
      modelOvf = 1'b1;
    end
  endtask

  task automatic endLoad();
    prog_en = 1'b0;
    @(negedge clk);
    checkOutput("end busy", 64'(busy), 64'h0);
    checkOutput("end prog_count", 64'(prog_count), 64'(modelCount));
    checkOutput("end prog_ovf", 64'(prog_ovf), 64'(modelOvf));
  endtask

  initial begin
    logic [31:0] held;
    logic [7:0]  firstLoad [8];
    vecs[0] = '{6'd0, 32'h8b00001e};
    vecs[1] = '{6'd1, 32'hd503201f};
    vecs[2] = '{6'd2, 32'h00000000};
    vecs[3] = '{6'd63, 32'h00000000};
    firstLoad = '{8'h1e, 8'h00, 8'h00, 8'h8b, 8'h1f, 8'h20, 8'h03, 8'hd5};

    reset = 1'b1; addr = '0; rd_en = 1'b0; prog_en = 1'b0; prog_valid = 1'b0; prog_byte = '0;
    modelAsm = '0; modelIdx = 0; modelCount = 0; modelOvf = 1'b0;

    doReset();
    for (int i = 0; i < 64; i++) fetch(6'(i), 32'h0);

    startLoad();
    for (int i = 0; i < 8; i++) applyStimulus(firstLoad[i]);
    endLoad();
    for (int i = 0; i < 4; i++) fetch(vecs[i].a, vecs[i].exp);

    // Stalled fetch holds the last word while the address wanders.
    fetch(6'd1, 32'hd503201f);
    held = 32'hd503201f;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      addr = 6'(10 + k);
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall hold q %0d", k), 64'(q), 64'(held));
      checkOutput($sformatf("stall hold q_valid %0d", k), 64'(q_valid), 64'h1);
    end

    startLoad();
    for (int i = 0; i < 256; i++) applyStimulus(8'($urandom_range(0, 255)));
    applyStimulus(8'hee);
    endLoad();
    fetch(6'd0, modelMem[0]);
    fetch(6'd37, modelMem[37]);
    fetch(6'd63, modelMem[63]);

    startLoad();
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'h40 + i));
    endLoad();
    fetch(6'd0, 32'h43424140);
    fetch(6'd1, modelMem[1]);
    fetch(6'd2, modelMem[2]);

    startLoad();
    for (int i = 0; i < 13; i++) applyStimulus(8'($urandom_range(0, 255)));
    checkOutput("midload prog_count", 64'(prog_count), 64'd3);
    doReset();
    for (int i = 0; i < 64; i++) fetch(6'(i), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
